// File: rtl/osd_ctrl.sv
// Purpose     : frame-synchronous config controller for the OSD overlay (shadow regs, vsync-aligned commit, blink).
// Latency     : outputs update on the frame-edge cycle and show on the next cycle; o_frame_tick pulses in that cycle.
// Backpressure: o_wr_ready is low while a commit waits for the next frame edge; otherwise writes take one cycle.
//
// Ports:
//   i_clk, i_rst              pixel clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready     host write handshake; i_wr_addr[2:0], i_wr_data[23:0]
//   i0_vs                     vsync of the stream entering the OSD stage (active level P_VS_POL)
//   o_en, o_bgr[23:0]         overlay enable / colour to the OSD stage
//   o_pending                 a commit is waiting for the next frame edge
//   o_frame_tick              one-cycle pulse in the cycle after each frame edge
//
// Register map: 0 CTRL {[15:8] half_period, [1] blink_en, [0] en}, 1 COL_A, 2 COL_B,
//               3 COMMIT (data ignored), 4 TIMEOUT, 5-7 accepted and dropped.
//
// Optional feature macro: OSD_CTRL_TIMEOUT_EN
//   defined   : TIMEOUT[15:0] limits how many frames the overlay stays enabled after a commit
//               (0 = no limit).
//   undefined : TIMEOUT writes are accepted and dropped; o_en follows the active enable.

module osd_ctrl #(
    parameter bit P_VS_POL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [2:0]  i_wr_addr,
    input  logic [23:0] i_wr_data,
    input  logic        i0_vs,
    output logic        o_en,
    output logic [23:0] o_bgr,
    output logic        o_pending,
    output logic        o_frame_tick
);

    localparam logic [2:0]  L_ADDR_CTRL    = 3'd0;
    localparam logic [2:0]  L_ADDR_COL_A   = 3'd1;
    localparam logic [2:0]  L_ADDR_COL_B   = 3'd2;
    localparam logic [2:0]  L_ADDR_COMMIT  = 3'd3;
`ifdef OSD_CTRL_TIMEOUT_EN
    localparam logic [2:0]  L_ADDR_TIMEOUT = 3'd4;
`endif
    localparam logic [23:0] L_COL_A_RST    = 24'hFFFFFF;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_vs_d;

    // Shadow copies written by the host
    logic        r_sh_en;
    logic        r_sh_blink;
    logic [7:0]  r_sh_half;
    logic [23:0] r_sh_col_a;
    logic [23:0] r_sh_col_b;

    // Active copies, only ever loaded on a frame edge
    logic        r_act_en;
    logic        r_act_blink;
    logic [7:0]  r_act_half;
    logic [23:0] r_act_col_a;
    logic [23:0] r_act_col_b;

    logic [7:0]  r_blink_cnt;
    logic        r_phase;

    logic        r_en;
    logic [23:0] r_bgr;
    logic        r_tick;

`ifdef OSD_CTRL_TIMEOUT_EN
    logic [15:0] r_sh_tmo;
    logic [15:0] r_act_tmo;
    logic [15:0] r_frm_cnt;
`endif

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic        w_ready;
    logic        w_pending;
    logic        w_edge;
    logic        w_wr_fire;
    logic        w_commit_wr;
    logic        w_apply;
    logic [7:0]  w_half_m1;
    logic        w_cnt_wrap;
    logic [7:0]  w_cnt_nxt;
    logic        w_phase_nxt;
    logic        w_en_nxt;
    logic [23:0] w_col_a_nxt;
    logic [23:0] w_col_b_nxt;
    logic [23:0] w_bgr_nxt;
    logic        w_oen_nxt;

    // A level already active when reset releases still counts as an edge,
    // because r_vs_d is held at the inactive level during reset.
    assign w_edge      = (i0_vs == P_VS_POL) && (r_vs_d != P_VS_POL);
    assign w_wr_fire   = i_wr_valid && w_ready;
    assign w_commit_wr = w_wr_fire && (i_wr_addr == L_ADDR_COMMIT);
    // A commit written in IDLE only reaches PEND after this cycle, so an edge
    // coinciding with the COMMIT write does not apply it.
    assign w_apply     = (r_state == S_PEND) && w_edge;

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_pending   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_commit_wr) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                w_pending = 1'b1;
                if (w_edge) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // half_period of 0 behaves like 1: wrap on every frame.
    assign w_half_m1  = (r_act_half == 8'd0) ? 8'd0 : (r_act_half - 8'd1);
    // >= keeps the counter bounded even if it ever sits above the wrap point.
    assign w_cnt_wrap = (r_blink_cnt >= w_half_m1);

    // Blink counter / phase. The commit edge restarts the pattern instead of counting.
    always_comb begin
        w_cnt_nxt   = r_blink_cnt;
        w_phase_nxt = r_phase;
        if (w_apply) begin
            w_cnt_nxt   = 8'd0;
            w_phase_nxt = 1'b0;
        end else if (w_edge) begin
            if (w_cnt_wrap) begin
                w_cnt_nxt   = 8'd0;
                w_phase_nxt = r_act_blink & ~r_phase;
            end else begin
                w_cnt_nxt   = r_blink_cnt + 8'd1;
                w_phase_nxt = r_act_blink & r_phase;
            end
        end
    end

    // Values the active registers will hold after this cycle; outputs are
    // computed from these so the commit frame already shows the new settings.
    assign w_en_nxt    = w_apply ? r_sh_en    : r_act_en;
    assign w_col_a_nxt = w_apply ? r_sh_col_a : r_act_col_a;
    assign w_col_b_nxt = w_apply ? r_sh_col_b : r_act_col_b;
    assign w_bgr_nxt   = w_phase_nxt ? w_col_b_nxt : w_col_a_nxt;

`ifdef OSD_CTRL_TIMEOUT_EN
    logic [15:0] w_frm_nxt;
    logic [15:0] w_tmo_nxt;
    logic        w_expired;

    always_comb begin
        w_frm_nxt = r_frm_cnt;
        if (w_apply) begin
            w_frm_nxt = 16'd0;
        end else if (w_edge && (r_frm_cnt != 16'hFFFF)) begin
            w_frm_nxt = r_frm_cnt + 16'd1;
        end
    end

    assign w_tmo_nxt = w_apply ? r_sh_tmo : r_act_tmo;
    assign w_expired = (w_tmo_nxt != 16'd0) && (w_frm_nxt >= w_tmo_nxt);
    assign w_oen_nxt = w_en_nxt && !w_expired;
`else
    assign w_oen_nxt = w_en_nxt;
`endif

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d <= !P_VS_POL;
        end else begin
            r_vs_d <= i0_vs;
        end
    end

    // Shadow registers. Writes only arrive in IDLE since ready is low in PEND.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_en    <= 1'b0;
            r_sh_blink <= 1'b0;
            r_sh_half  <= 8'd0;
            r_sh_col_a <= L_COL_A_RST;
            r_sh_col_b <= 24'd0;
`ifdef OSD_CTRL_TIMEOUT_EN
            r_sh_tmo   <= 16'd0;
`endif
        end else if (w_wr_fire) begin
            case (i_wr_addr)
                L_ADDR_CTRL: begin
                    r_sh_en    <= i_wr_data[0];
                    r_sh_blink <= i_wr_data[1];
                    r_sh_half  <= i_wr_data[15:8];
                end
                L_ADDR_COL_A: r_sh_col_a <= i_wr_data;
                L_ADDR_COL_B: r_sh_col_b <= i_wr_data;
`ifdef OSD_CTRL_TIMEOUT_EN
                L_ADDR_TIMEOUT: r_sh_tmo <= i_wr_data[15:0];
`endif
                default: ;
            endcase
        end
    end

    // Active registers: atomic copy of the whole shadow set on the commit edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act_en    <= 1'b0;
            r_act_blink <= 1'b0;
            r_act_half  <= 8'd0;
            r_act_col_a <= L_COL_A_RST;
            r_act_col_b <= 24'd0;
`ifdef OSD_CTRL_TIMEOUT_EN
            r_act_tmo   <= 16'd0;
`endif
        end else if (w_apply) begin
            r_act_en    <= r_sh_en;
            r_act_blink <= r_sh_blink;
            r_act_half  <= r_sh_half;
            r_act_col_a <= r_sh_col_a;
            r_act_col_b <= r_sh_col_b;
`ifdef OSD_CTRL_TIMEOUT_EN
            r_act_tmo   <= r_sh_tmo;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

`ifdef OSD_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frm_cnt <= 16'd0;
        end else begin
            r_frm_cnt <= w_frm_nxt;
        end
    end
`endif

    // Overlay outputs only move on a frame edge, so nothing changes mid-frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en   <= 1'b0;
            r_bgr  <= L_COL_A_RST;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_edge;
            if (w_edge) begin
                r_en  <= w_oen_nxt;
                r_bgr <= w_bgr_nxt;
            end
        end
    end

    assign o_wr_ready   = w_ready;
    assign o_pending    = w_pending;
    assign o_en         = r_en;
    assign o_bgr        = r_bgr;
    assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_osd_ctrl.sv
// Directed bench for osd_ctrl: reset state, idle frames, commit, blink pattern,
// commit coinciding with an edge, back-to-back writes, reset while pending, timeout.

module tb_osd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        vs;
    logic        en;
    logic [23:0] bgr;
    logic        pending;
    logic        tick;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    osd_ctrl #(.P_VS_POL(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i0_vs        (vs),
        .o_en         (en),
        .o_bgr        (bgr),
        .o_pending    (pending),
        .o_frame_tick (tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write; waits (bounded) for ready, holds valid for exactly the accepting edge.
    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        int w;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        w = 0;
        while (!wr_ready && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) begin
            n_checks++;
            $display("FAIL wr_ready_timeout: ready=%0b, required 1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
    endtask

    // One vsync frame: 2 cycles active, 6 inactive. Captures outputs in the
    // cycle after the edge, counts any further ticks, and whether the outputs
    // stayed put for the rest of the frame.
    task automatic frame(output logic t, output logic e, output logic [23:0] b,
                         output logic p, output int extra, output logic stable);
        vs = 1'b1;
        step();
        t = tick;
        e = en;
        b = bgr;
        p = pending;
        extra = 0;
        step();
        if (tick) extra++;
        vs = 1'b0;
        repeat (6) begin
            step();
            if (tick) extra++;
        end
        stable = (en === e) && (bgr === b);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 24'd0; vs = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        n_checks++; if (en !== 1'b0) $display("FAIL reset_en: got %0b want 0", en); else n_pass++;
        n_checks++; if (bgr !== 24'hFFFFFF) $display("FAIL reset_bgr: got %h want ffffff", bgr); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %0b want 0", pending); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick: got %0b want 0", tick); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", wr_ready); else n_pass++;
    endtask

    task automatic test_idle_frames();
        logic t, e, p, s; logic [23:0] b; int x;
        for (int i = 0; i < 3; i++) begin
            frame(t, e, b, p, x, s);
            n_checks++; if (t !== 1'b1) $display("FAIL idle_tick[%0d]: got %0b want 1", i, t); else n_pass++;
            n_checks++; if (x != 0) $display("FAIL idle_extra_ticks[%0d]: got %0d want 0", i, x); else n_pass++;
        end
        n_checks++; if (e !== 1'b0) $display("FAIL idle_en: got %0b want 0", e); else n_pass++;
        n_checks++; if (b !== 24'hFFFFFF) $display("FAIL idle_bgr: got %h want ffffff", b); else n_pass++;
    endtask

    task automatic test_commit();
        logic t, e, p, s; logic [23:0] b; int x;
        wr(3'd0, 24'h000001);
        wr(3'd1, 24'h0000FF);
        wr(3'd3, 24'h0);
        n_checks++; if (pending !== 1'b1) $display("FAIL commit_pending: got %0b want 1", pending); else n_pass++;
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL commit_ready: got %0b want 0", wr_ready); else n_pass++;
        n_checks++; if (en !== 1'b0) $display("FAIL commit_en_before_edge: got %0b want 0", en); else n_pass++;
        frame(t, e, b, p, x, s);
        n_checks++; if (t !== 1'b1) $display("FAIL commit_tick: got %0b want 1", t); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL commit_en: got %0b want 1", e); else n_pass++;
        n_checks++; if (b !== 24'h0000FF) $display("FAIL commit_bgr: got %h want 0000ff", b); else n_pass++;
        n_checks++; if (p !== 1'b0) $display("FAIL commit_pending_drop: got %0b want 0", p); else n_pass++;
        n_checks++; if (s !== 1'b1) $display("FAIL commit_stable: got %0b want 1", s); else n_pass++;
    endtask

    task automatic test_blink();
        logic t, e, p, s; logic [23:0] b; int x;
        logic [23:0] exp_col [5];
        exp_col = '{24'h0000FF, 24'h0000FF, 24'h00FF00, 24'h00FF00, 24'h0000FF};
        wr(3'd0, 24'h000203);
        wr(3'd2, 24'h00FF00);
        wr(3'd3, 24'h0);
        for (int i = 0; i < 5; i++) begin
            frame(t, e, b, p, x, s);
            n_checks++; if (b !== exp_col[i]) $display("FAIL blink_bgr[%0d]: got %h want %h", i, b, exp_col[i]); else n_pass++;
            n_checks++; if (t !== 1'b1 || x != 0) $display("FAIL blink_tick[%0d]: got %0b/%0d want 1/0", i, t, x); else n_pass++;
            n_checks++; if (s !== 1'b1) $display("FAIL blink_stable[%0d]: got %0b want 1", i, s); else n_pass++;
        end
    endtask

    // Blink state here: cnt=0, phase=0 (half=2). The coincident edge counts
    // normally (cnt->1, still colour A) and the commit waits one more frame.
    task automatic test_commit_on_edge();
        logic t, e, p, s; logic [23:0] b; int x;
        wr(3'd0, 24'h000001);
        wr(3'd1, 24'hFF0000);
        vs = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 24'd0;
        step();
        wr_valid = 1'b0;
        n_checks++; if (tick !== 1'b1) $display("FAIL edge_commit_tick: got %0b want 1", tick); else n_pass++;
        n_checks++; if (bgr !== 24'h0000FF) $display("FAIL edge_commit_not_applied: got %h want 0000ff", bgr); else n_pass++;
        n_checks++; if (pending !== 1'b1) $display("FAIL edge_commit_pending: got %0b want 1", pending); else n_pass++;
        step();
        vs = 1'b0;
        repeat (6) step();
        frame(t, e, b, p, x, s);
        n_checks++; if (b !== 24'hFF0000) $display("FAIL edge_commit_next_bgr: got %h want ff0000", b); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL edge_commit_next_en: got %0b want 1", e); else n_pass++;
        n_checks++; if (p !== 1'b0) $display("FAIL edge_commit_next_pending: got %0b want 0", p); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic t, e, p, s; logic [23:0] b; int x;
        wr(3'd1, 24'h111111);
        wr(3'd1, 24'h222222);
        wr(3'd5, 24'h333333);
        wr(3'd0, 24'h000001);
        wr(3'd3, 24'h0);
        frame(t, e, b, p, x, s);
        n_checks++; if (b !== 24'h222222) $display("FAIL b2b_bgr: got %h want 222222", b); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL b2b_en: got %0b want 1", e); else n_pass++;
    endtask

    task automatic test_reset_pend();
        logic t, e, p, s; logic [23:0] b; int x;
        rst = 1'b1; step(); rst = 1'b0;
        wr(3'd0, 24'h000001);
        wr(3'd1, 24'h00ABCD);
        wr(3'd3, 24'h0);
        n_checks++; if (pending !== 1'b1) $display("FAIL rstpend_pending_before: got %0b want 1", pending); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (pending !== 1'b0) $display("FAIL rstpend_pending: got %0b want 0", pending); else n_pass++;
        n_checks++; if (en !== 1'b0) $display("FAIL rstpend_en: got %0b want 0", en); else n_pass++;
        n_checks++; if (bgr !== 24'hFFFFFF) $display("FAIL rstpend_bgr: got %h want ffffff", bgr); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL rstpend_ready: got %0b want 1", wr_ready); else n_pass++;
        frame(t, e, b, p, x, s);
        n_checks++; if (t !== 1'b1) $display("FAIL rstpend_tick: got %0b want 1", t); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL rstpend_next_en: got %0b want 0", e); else n_pass++;
        n_checks++; if (b !== 24'hFFFFFF) $display("FAIL rstpend_next_bgr: got %h want ffffff", b); else n_pass++;
        // vsync already active while reset releases: first cycle counts as an edge
        vs = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_checks++; if (tick !== 1'b1) $display("FAIL rst_level_edge_tick: got %0b want 1", tick); else n_pass++;
        vs = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_timeout();
        logic t, e, p, s; logic [23:0] b; int x;
`ifdef OSD_CTRL_TIMEOUT_EN
        logic exp_en [5];
        exp_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        rst = 1'b1; step(); rst = 1'b0;
        wr(3'd4, 24'h000003);
        wr(3'd0, 24'h000001);
        wr(3'd1, 24'h0000FF);
        wr(3'd3, 24'h0);
        for (int i = 0; i < 5; i++) begin
            frame(t, e, b, p, x, s);
`ifdef OSD_CTRL_TIMEOUT_EN
            n_checks++; if (e !== exp_en[i]) $display("FAIL timeout_en[%0d]: got %0b want %0b", i, e, exp_en[i]); else n_pass++;
`else
            n_checks++; if (e !== 1'b1) $display("FAIL timeout_ignored_en[%0d]: got %0b want 1", i, e); else n_pass++;
`endif
        end
        wr(3'd3, 24'h0);
        frame(t, e, b, p, x, s);
        n_checks++; if (e !== 1'b1) $display("FAIL timeout_recommit_en: got %0b want 1", e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_commit();
        test_blink();
        test_commit_on_edge();
        test_back_to_back();
        test_reset_pend();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
